// File: rtl/hazard_pkg.sv
// Shared types for the hazard unit: in-flight slot record and operand-mux select codes.
package hazard_pkg;

  localparam int unsigned REG_ADDR_WIDTH = 5;

  typedef struct packed {
    logic                      valid;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic                      reg_write;
    logic                      mem_read;
  } hazard_slot_t;

  // Encodings follow the EX operand-mux input order.
  typedef enum logic [1:0] {
    FWD_REGFILE = 2'd0,
    FWD_MEM     = 2'd1,
    FWD_WB      = 2'd2,
    FWD_RETIRED = 2'd3
  } fwd_sel_e;

endpackage

// File: rtl/pipeline_hazard_unit_slot_match.sv
// True when one in-flight slot will write a given architectural register (x0 never matches).
module slot_match
  import hazard_pkg::*;
(
  input  hazard_slot_t              slot,
  input  logic [REG_ADDR_WIDTH-1:0] reg_idx,
  output logic                      match
);

  // A slot produces r when it is a live register writer targeting a non-zero r.
  always_comb begin
    match = slot.valid && slot.reg_write && (slot.rd == reg_idx) && (slot.rd != '0);
  end

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Tracks EX/MEM/WB/RET destination state; drives registered forwarding selects,
// the load-use stall and branch flush controls.
module pipeline_hazard_unit #(
  parameter int unsigned REG_ADDR_WIDTH = hazard_pkg::REG_ADDR_WIDTH,
  parameter int unsigned FWD_SEL_WIDTH  = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      pipeline_enable,
  input  logic                      decode_valid,
  input  logic [REG_ADDR_WIDTH-1:0] decode_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] decode_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] decode_rd,
  input  logic                      decode_uses_rs1,
  input  logic                      decode_uses_rs2,
  input  logic                      decode_reg_write,
  input  logic                      decode_mem_read,
  input  logic                      branch_taken,
  output logic [FWD_SEL_WIDTH-1:0]  fwd_sel_rs1,
  output logic [FWD_SEL_WIDTH-1:0]  fwd_sel_rs2,
  output logic                      stall_fetch_decode,
  output logic                      flush_decode,
  output logic                      flush_execute
);

  import hazard_pkg::*;

  hazard_slot_t ex_q, ex_d, mem_q, mem_d, wb_q, wb_d, ret_q, ret_d;
  fwd_sel_e     fwd_sel_rs1_q, fwd_sel_rs1_d, fwd_sel_rs2_q, fwd_sel_rs2_d;

  logic ex_rs1, ex_rs2, mem_rs1, mem_rs2, wb_rs1, wb_rs2;
  logic load_use;

  // Current EX/MEM/WB become next MEM/WB/RET, so they map to codes 1/2/3.
  slot_match u_ex_rs1  (.slot(ex_q),  .reg_idx(decode_rs1), .match(ex_rs1));
  slot_match u_ex_rs2  (.slot(ex_q),  .reg_idx(decode_rs2), .match(ex_rs2));
  slot_match u_mem_rs1 (.slot(mem_q), .reg_idx(decode_rs1), .match(mem_rs1));
  slot_match u_mem_rs2 (.slot(mem_q), .reg_idx(decode_rs2), .match(mem_rs2));
  slot_match u_wb_rs1  (.slot(wb_q),  .reg_idx(decode_rs1), .match(wb_rs1));
  slot_match u_wb_rs2  (.slot(wb_q),  .reg_idx(decode_rs2), .match(wb_rs2));

  // Hazard controls: branch overrides the load-use stall; everything is quiet while disabled.
  always_comb begin
    load_use = decode_valid && ex_q.mem_read &&
               ((decode_uses_rs1 && ex_rs1) || (decode_uses_rs2 && ex_rs2));
    stall_fetch_decode = pipeline_enable && load_use && !branch_taken;
    flush_decode       = pipeline_enable && branch_taken;
    flush_execute      = pipeline_enable && (load_use || branch_taken);
  end

  // Slot shift and forwarding-select computation for the instruction entering EX.
  always_comb begin
    ex_d          = ex_q;
    mem_d         = mem_q;
    wb_d          = wb_q;
    ret_d         = ret_q;
    fwd_sel_rs1_d = fwd_sel_rs1_q;
    fwd_sel_rs2_d = fwd_sel_rs2_q;
    if (pipeline_enable) begin
      ret_d         = wb_q;
      wb_d          = mem_q;
      mem_d         = ex_q;
      ex_d          = '0;
      fwd_sel_rs1_d = FWD_REGFILE;
      fwd_sel_rs2_d = FWD_REGFILE;
      if (decode_valid && !load_use && !branch_taken) begin
        ex_d.valid     = 1'b1;
        ex_d.rd        = decode_rd;
        ex_d.reg_write = decode_reg_write;
        ex_d.mem_read  = decode_mem_read;
        // Youngest producer wins: MEM > WB > RET > regfile.
        if (decode_uses_rs1) begin
          if (ex_rs1)       fwd_sel_rs1_d = FWD_MEM;
          else if (mem_rs1) fwd_sel_rs1_d = FWD_WB;
          else if (wb_rs1)  fwd_sel_rs1_d = FWD_RETIRED;
        end
        if (decode_uses_rs2) begin
          if (ex_rs2)       fwd_sel_rs2_d = FWD_MEM;
          else if (mem_rs2) fwd_sel_rs2_d = FWD_WB;
          else if (wb_rs2)  fwd_sel_rs2_d = FWD_RETIRED;
        end
      end
    end
  end

  // State registers; reset discards every in-flight slot immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_q          <= '0;
      mem_q         <= '0;
      wb_q          <= '0;
      ret_q         <= '0;
      fwd_sel_rs1_q <= FWD_REGFILE;
      fwd_sel_rs2_q <= FWD_REGFILE;
    end else begin
      ex_q          <= ex_d;
      mem_q         <= mem_d;
      wb_q          <= wb_d;
      ret_q         <= ret_d;
      fwd_sel_rs1_q <= fwd_sel_rs1_d;
      fwd_sel_rs2_q <= fwd_sel_rs2_d;
    end
  end

  assign fwd_sel_rs1 = fwd_sel_rs1_q;
  assign fwd_sel_rs2 = fwd_sel_rs2_q;

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Directed scoreboard bench for pipeline_hazard_unit.
module tb_pipeline_hazard_unit;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       pipeline_enable;
  logic       decode_valid;
  logic [4:0] decode_rs1, decode_rs2, decode_rd;
  logic       decode_uses_rs1, decode_uses_rs2;
  logic       decode_reg_write, decode_mem_read;
  logic       branch_taken;
  logic [1:0] fwd_sel_rs1, fwd_sel_rs2;
  logic       stall_fetch_decode, flush_decode, flush_execute;

  pipeline_hazard_unit #(.REG_ADDR_WIDTH(5), .FWD_SEL_WIDTH(2)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .pipeline_enable   (pipeline_enable),
    .decode_valid      (decode_valid),
    .decode_rs1        (decode_rs1),
    .decode_rs2        (decode_rs2),
    .decode_rd         (decode_rd),
    .decode_uses_rs1   (decode_uses_rs1),
    .decode_uses_rs2   (decode_uses_rs2),
    .decode_reg_write  (decode_reg_write),
    .decode_mem_read   (decode_mem_read),
    .branch_taken      (branch_taken),
    .fwd_sel_rs1       (fwd_sel_rs1),
    .fwd_sel_rs2       (fwd_sel_rs2),
    .stall_fetch_decode(stall_fetch_decode),
    .flush_decode      (flush_decode),
    .flush_execute     (flush_execute)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int         id;
    logic [1:0] s1;
    logic [1:0] s2;
    logic       st;
    logic       fd;
    logic       fe;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   step_id  = 0;

  task automatic chk(input string nm, input int id, input int got, input int expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL step%0d %s got=%0d expected=%0d", id, nm, got, expv);
    end
  endtask

  // Monitor: each cycle's expectation is compared mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("fwd_sel_rs1",   e.id, int'(fwd_sel_rs1),        int'(e.s1));
      chk("fwd_sel_rs2",   e.id, int'(fwd_sel_rs2),        int'(e.s2));
      chk("stall",         e.id, int'(stall_fetch_decode), int'(e.st));
      chk("flush_decode",  e.id, int'(flush_decode),       int'(e.fd));
      chk("flush_execute", e.id, int'(flush_execute),      int'(e.fe));
    end
  end

  // Drive one cycle of decode inputs and record the outputs expected in that cycle.
  task automatic step(input logic rst, input logic en, input logic v,
                      input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                      input logic u1, input logic u2, input logic rw, input logic mr,
                      input logic br,
                      input logic [1:0] s1, input logic [1:0] s2,
                      input logic st, input logic fd, input logic fe);
    exp_t e;
    @(posedge clk);
    #1;
    reset_n          = rst;
    pipeline_enable  = en;
    decode_valid     = v;
    decode_rs1       = r1;
    decode_rs2       = r2;
    decode_rd        = rd;
    decode_uses_rs1  = u1;
    decode_uses_rs2  = u2;
    decode_reg_write = rw;
    decode_mem_read  = mr;
    branch_taken     = br;
    step_id++;
    e.id = step_id; e.s1 = s1; e.s2 = s2; e.st = st; e.fd = fd; e.fe = fe;
    q.push_back(e);
  endtask

  task automatic nop(input logic [1:0] s1, input logic [1:0] s2);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, s1, s2, 0, 0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; pipeline_enable = 1'b1; decode_valid = 1'b0;
    decode_rs1 = '0; decode_rs2 = '0; decode_rd = '0;
    decode_uses_rs1 = 1'b0; decode_uses_rs2 = 1'b0;
    decode_reg_write = 1'b0; decode_mem_read = 1'b0; branch_taken = 1'b0;

    // rst en v  r1 r2 rd  u1 u2 rw mr br  s1 s2 st fd fe
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);   // in reset
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    nop(0, 0); nop(0, 0); nop(0, 0);                         // idle after release

    // addi x5 ; add x6,x5,x5
    step(1, 1, 1, 0, 0, 5,  1, 0, 1, 0, 0,  0, 0, 0, 0, 0);
    step(1, 1, 1, 5, 5, 6,  1, 1, 1, 0, 0,  0, 0, 0, 0, 0);
    nop(1, 1);

    // lw x7 ; add x8,x7,x1 (stall once, then WB forward)
    step(1, 1, 1, 2, 0, 7,  1, 0, 1, 1, 0,  0, 0, 0, 0, 0);
    step(1, 1, 1, 7, 1, 8,  1, 1, 1, 0, 0,  0, 0, 1, 0, 1);
    step(1, 1, 1, 7, 1, 8,  1, 1, 1, 0, 0,  0, 0, 0, 0, 0);
    nop(2, 0);

    // x9 producer, two unrelated, consumer (rs2 unused) -> RET; x0 never forwards
    step(1, 1, 1, 0, 0, 9,  1, 0, 1, 0, 0,  0, 0, 0, 0, 0);
    step(1, 1, 1, 11, 0, 10, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 13, 0, 12, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 9, 9, 14, 1, 0, 1, 0, 0,  0, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0,  1, 0, 1, 0, 0,  3, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0, 15, 1, 1, 1, 0, 0,  0, 0, 0, 0, 0);
    nop(0, 0);

    // back-to-back writers of x16: youngest wins
    step(1, 1, 1, 0, 0, 16, 1, 0, 1, 0, 0,  0, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0, 16, 1, 0, 1, 0, 0,  0, 0, 0, 0, 0);
    step(1, 1, 1, 16, 16, 17, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    nop(1, 1);

    // load two ahead of consumer: no stall, WB select; rs2 from MEM
    step(1, 1, 1, 0, 0, 18, 1, 0, 1, 1, 0,  0, 0, 0, 0, 0);
    step(1, 1, 1, 20, 0, 19, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 18, 19, 21, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    nop(2, 1);

    // load-use coinciding with a taken branch: flush wins, EX gets a bubble
    step(1, 1, 1, 0, 0, 22, 1, 0, 1, 1, 0,  0, 0, 0, 0, 0);
    step(1, 1, 1, 22, 0, 23, 1, 0, 1, 0, 1, 0, 0, 0, 1, 1);
    step(1, 1, 1, 23, 22, 24, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    nop(0, 2);

    // pipeline_enable low for 2 cycles holds selects and slots, masks flushes
    step(1, 1, 1, 0, 0, 25, 1, 0, 1, 0, 0,  0, 0, 0, 0, 0);
    step(1, 1, 1, 25, 25, 26, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 3, 4, 1,  1, 1, 1, 0, 1,  1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  1, 1, 0, 0, 0);
    nop(1, 1);
    step(1, 1, 1, 26, 25, 27, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    nop(2, 3);

    // load-use masked while disabled, detected on re-enable
    step(1, 1, 1, 0, 0, 28, 1, 0, 1, 1, 0,  0, 0, 0, 0, 0);
    step(1, 0, 1, 28, 0, 29, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 28, 0, 29, 1, 0, 1, 0, 0, 0, 0, 1, 0, 1);
    step(1, 1, 1, 28, 0, 29, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    nop(2, 0);

    // asynchronous reset between producer and consumer
    step(1, 1, 1, 0, 0, 30, 1, 0, 1, 0, 0,  0, 0, 0, 0, 0);
    step(1, 1, 1, 30, 30, 31, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    step(1, 1, 1, 30, 30, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    nop(0, 0);

    repeat (2) @(posedge clk);
    chk("scoreboard_drained", 0, q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
